// File: rtl/a2_bus_initiator.sv
// Apple II slot-bus master: derives PHI0/PHI1/Q3 from C7M and runs at most one
// command per bus cycle (accepted at P6, launched at P0, response strobe at the next P0).
module a2_bus_initiator #(
  parameter int          SLOT      = 1,
  parameter bit          LONG_EN   = 1'b1,
  parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
  input  logic        C7M,
  input  logic        nRES,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_addr,
  input  logic        cmd_we,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        PHI0,
  output logic        PHI1,
  output logic        Q3,
  output logic [15:0] A,
  output logic        nWE,
  output logic        nDEVSEL,
  output logic        nIOSEL,
  output logic        nIOSTRB,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in
);

  typedef enum logic [2:0] {
    PH0 = 3'd0,
    PH1 = 3'd1,
    PH2 = 3'd2,
    PH3 = 3'd3,
    PH4 = 3'd4,
    PH5 = 3'd5,
    PH6 = 3'd6,
    PHX = 3'd7
  } phase_t;

  localparam logic [11:0] DEV_BASE = 12'(12'hC08 + SLOT);
  localparam logic [7:0]  IO_BASE  = 8'(8'hC0 + SLOT);

  phase_t      phase, phase_nxt;
  logic [6:0]  lcnt, lcnt_nxt;
  logic        busy, busy_nxt;
  logic        cur_we, cur_we_nxt;
  logic        cyc_end, accept, in_phi0;
  logic        dev_hit, io_hit, strb_hit;
  logic        phi0_nxt, phi1_nxt, q3_nxt, nwe_nxt, doe_nxt, rdy_nxt, rspv_nxt;
  logic        ndevsel_nxt, niosel_nxt, niostrb_nxt;
  logic [15:0] a_nxt;
  logic [7:0]  dout_nxt, rdata_nxt;

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      phase     <= PH0;
      lcnt      <= 7'd0;
      busy      <= 1'b0;
      cur_we    <= 1'b0;
      PHI0      <= 1'b0;
      PHI1      <= 1'b1;
      Q3        <= 1'b0;
      A         <= 16'h0000;
      nWE       <= 1'b1;
      nDEVSEL   <= 1'b1;
      nIOSEL    <= 1'b1;
      nIOSTRB   <= 1'b1;
      D_out     <= 8'h00;
      D_oe      <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      phase     <= phase_nxt;
      lcnt      <= lcnt_nxt;
      busy      <= busy_nxt;
      cur_we    <= cur_we_nxt;
      PHI0      <= phi0_nxt;
      PHI1      <= phi1_nxt;
      Q3        <= q3_nxt;
      A         <= a_nxt;
      nWE       <= nwe_nxt;
      nDEVSEL   <= ndevsel_nxt;
      nIOSEL    <= niosel_nxt;
      nIOSTRB   <= niostrb_nxt;
      D_out     <= dout_nxt;
      D_oe      <= doe_nxt;
      cmd_ready <= rdy_nxt;
      rsp_valid <= rspv_nxt;
      rsp_rdata <= rdata_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    cyc_end   = (phase == PH6);
    accept    = cyc_end && cmd_valid && cmd_ready;

    case (phase)
      PH0:     phase_nxt = PH1;
      PH1:     phase_nxt = PH2;
      PH2:     phase_nxt = (LONG_EN && (lcnt == 7'd64)) ? PHX : PH3;
      PHX:     phase_nxt = PH3;
      PH3:     phase_nxt = PH4;
      PH4:     phase_nxt = PH5;
      PH5:     phase_nxt = PH6;
      PH6:     phase_nxt = PH0;
      default: phase_nxt = PH0;
    endcase

    lcnt_nxt = lcnt;
    if (cyc_end) begin
      lcnt_nxt = (lcnt == 7'd64) ? 7'd0 : lcnt + 7'd1;
    end

    // Address, direction and write data change only on the P6 -> P0 boundary.
    busy_nxt   = busy;
    cur_we_nxt = cur_we;
    a_nxt      = A;
    nwe_nxt    = nWE;
    dout_nxt   = D_out;
    if (cyc_end) begin
      busy_nxt   = accept;
      cur_we_nxt = accept && cmd_we;
      a_nxt      = accept ? cmd_addr : IDLE_ADDR;
      nwe_nxt    = !(accept && cmd_we);
      if (accept && cmd_we) begin
        dout_nxt = cmd_wdata;
      end
    end

    in_phi0  = phase_nxt inside {PH3, PH4, PH5, PH6};
    phi0_nxt = in_phi0;
    phi1_nxt = !in_phi0;
    q3_nxt   = phase_nxt inside {PH0, PH1, PH3, PH4};

    // Decode windows are disjoint, so at most one select can be low.
    dev_hit  = (A[15:4] == DEV_BASE);
    io_hit   = (A[15:8] == IO_BASE);
    strb_hit = (A[15:11] == 5'b11001);

    ndevsel_nxt = !(busy && in_phi0 && dev_hit);
    niosel_nxt  = !(busy && in_phi0 && io_hit);
    niostrb_nxt = !(busy && in_phi0 && strb_hit);

    // Drive only late in PHI0 so the bus is never fought across a turnaround.
    doe_nxt  = busy && cur_we && (phase_nxt inside {PH4, PH5, PH6});
    rdy_nxt  = (phase_nxt == PH6);
    rspv_nxt = cyc_end && busy;
    rdata_nxt = (cyc_end && busy && !cur_we) ? D_in : rsp_rdata;
  end

endmodule

// File: tb/tb_a2_bus_initiator.sv
// Directed bench for a2_bus_initiator: free-run timing, select decode for register,
// slot ROM and strobe accesses, back-to-back reads, an unmapped read and reset mid-write.
module tb_a2_bus_initiator;

  localparam int          SLOT      = 1;
  localparam bit          LONG_EN   = 1'b1;
  localparam logic [15:0] IDLE_ADDR = 16'h0000;

  if (SLOT < 1 || SLOT > 7) begin : g_slot_chk
    initial $fatal(1, "SLOT parameter outside 1..7");
  end

  logic        C7M, nRES;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        PHI0, PHI1, Q3, nWE, nDEVSEL, nIOSEL, nIOSTRB, D_oe;
  logic [15:0] A;
  logic [7:0]  D_out, D_in;

  a2_bus_initiator #(.SLOT(SLOT), .LONG_EN(LONG_EN), .IDLE_ADDR(IDLE_ADDR)) dut (
    .C7M(C7M), .nRES(nRES),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_we(cmd_we), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .PHI0(PHI0), .PHI1(PHI1), .Q3(Q3), .A(A), .nWE(nWE),
    .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .nIOSTRB(nIOSTRB),
    .D_out(D_out), .D_oe(D_oe), .D_in(D_in)
  );

  initial C7M = 1'b0;
  always #5 C7M = ~C7M;

  int n_cmp = 0;
  int n_bad = 0;
  int ph    = 0;

  int last_rise, run, n7, n8, long_at, bad_per, bad_hi, phi_bad, sel_seen, we_seen, rsp_seen;
  logic prev;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge C7M);
    @(negedge C7M);
    ph = (ph == 6) ? 0 : ph + 1;
  endtask

  // Present a command during P6 so the edge ending P6 accepts it.
  task automatic issue(input logic [15:0] addr, input logic we, input logic [7:0] wd);
    while (ph != 6) tick();
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_we    = we;
    cmd_wdata = wd;
    chk1($sformatf("rdy_p6_%h", addr), cmd_ready, 1'b1);
  endtask

  // Walks P0..P6 of a launched cycle, checking timing, selects and drive enable.
  task automatic run_cycle(input string tag, input logic [15:0] addr, input bit we,
                           input bit dev, input bit io, input bit strb);
    for (int p = 0; p <= 6; p++) begin
      if (p != 0) tick();
      chk1($sformatf("%s_p%0d_phi0", tag, p), PHI0, p >= 3);
      chk1($sformatf("%s_p%0d_q3", tag, p), Q3, p == 0 || p == 1 || p == 3 || p == 4);
      chk16($sformatf("%s_p%0d_a", tag, p), A, addr);
      chk1($sformatf("%s_p%0d_nwe", tag, p), nWE, !we);
      chk1($sformatf("%s_p%0d_dev", tag, p), nDEVSEL, !(dev && p >= 3));
      chk1($sformatf("%s_p%0d_io", tag, p), nIOSEL, !(io && p >= 3));
      chk1($sformatf("%s_p%0d_strb", tag, p), nIOSTRB, !(strb && p >= 3));
      chk1($sformatf("%s_p%0d_oe", tag, p), D_oe, we && p >= 4);
      chk1($sformatf("%s_p%0d_rdy", tag, p), cmd_ready, p == 6);
      if (p != 0) chk1($sformatf("%s_p%0d_rsp", tag, p), rsp_valid, 1'b0);
    end
  endtask

  initial begin
    nRES = 1'b1; cmd_valid = 1'b0; cmd_addr = 16'h0; cmd_we = 1'b0;
    cmd_wdata = 8'h0; D_in = 8'h00;
    #1 nRES = 1'b0;
    repeat (3) @(negedge C7M);

    chk1("rst_phi0", PHI0, 1'b0);     chk1("rst_phi1", PHI1, 1'b1);
    chk1("rst_q3", Q3, 1'b0);         chk16("rst_a", A, 16'h0000);
    chk1("rst_nwe", nWE, 1'b1);       chk1("rst_dev", nDEVSEL, 1'b1);
    chk1("rst_io", nIOSEL, 1'b1);     chk1("rst_strb", nIOSTRB, 1'b1);
    chk8("rst_dout", D_out, 8'h00);   chk1("rst_oe", D_oe, 1'b0);
    chk1("rst_rdy", cmd_ready, 1'b0); chk1("rst_rsp", rsp_valid, 1'b0);
    chk8("rst_rdata", rsp_rdata, 8'h00);

    // Free run: cycle 64 after release is the first long one.
    nRES = 1'b1;
    prev = 1'b0; run = 0; last_rise = -1; n7 = 0; n8 = 0; long_at = -1;
    bad_per = 0; bad_hi = 0; phi_bad = 0; sel_seen = 0; we_seen = 0; rsp_seen = 0;
    for (int k = 1; k <= 470; k++) begin
      @(posedge C7M);
      @(negedge C7M);
      if (PHI0 && !prev) begin
        if (last_rise >= 0) begin
          if (k - last_rise == 7) n7++;
          else if (k - last_rise == 8) begin n8++; long_at = last_rise; end
          else bad_per++;
        end
        last_rise = k;
        run = 0;
      end
      if (PHI0) run++;
      if (!PHI0 && prev && run != 4) bad_hi++;
      if (PHI1 === PHI0) phi_bad++;
      if (!nDEVSEL || !nIOSEL || !nIOSTRB) sel_seen++;
      if (!nWE) we_seen++;
      if (rsp_valid) rsp_seen++;
      prev = PHI0;
    end
    chki("free_n7", n7, 65);          chki("free_n8", n8, 1);
    chki("free_long_at", long_at, 444);
    chki("free_bad_per", bad_per, 0); chki("free_hi_len", bad_hi, 0);
    chki("free_phi_cmp", phi_bad, 0); chki("free_sel", sel_seen, 0);
    chki("free_nwe", we_seen, 0);     chki("free_rsp", rsp_seen, 0);
    ph = 0;

    // Write to slot-1 device register.
    issue(16'hC09F, 1'b1, 8'hE5);
    tick();
    cmd_valid = 1'b0;
    chk8("wr_dout", D_out, 8'hE5);
    run_cycle("wr", 16'hC09F, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk1("wr_rsp", rsp_valid, 1'b1);
    chk8("wr_rdata_keep", rsp_rdata, 8'h00);
    chk16("wr_idle_a", A, IDLE_ADDR);
    chk1("wr_idle_nwe", nWE, 1'b1);
    tick();
    chk1("wr_rsp_off", rsp_valid, 1'b0);

    // Read from slot-1 ROM.
    D_in = 8'h5A;
    issue(16'hC100, 1'b0, 8'h00);
    tick();
    cmd_valid = 1'b0;
    run_cycle("rd", 16'hC100, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk1("rd_rsp", rsp_valid, 1'b1);
    chk8("rd_rdata", rsp_rdata, 8'h5A);
    D_in = 8'hA5;
    tick();
    chk1("rd_rsp_off", rsp_valid, 1'b0);
    chk8("rd_rdata_hold", rsp_rdata, 8'h5A);

    // Back-to-back strobe reads with cmd_valid held.
    D_in = 8'h11;
    issue(16'hCFFF, 1'b0, 8'h00);
    tick();
    cmd_addr = 16'hC800;
    run_cycle("b2b1", 16'hCFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk1("b2b1_rsp", rsp_valid, 1'b1);
    chk8("b2b1_rdata", rsp_rdata, 8'h11);
    D_in = 8'h22;
    run_cycle("b2b2", 16'hC800, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk1("b2b2_rsp_gap7", rsp_valid, 1'b1);
    chk8("b2b2_rdata", rsp_rdata, 8'h22);
    tick();
    chk1("b2b2_rsp_off", rsp_valid, 1'b0);

    // Another slot's device window: no select, response still returned.
    D_in = 8'h3C;
    issue(16'hC0A0, 1'b0, 8'h00);
    tick();
    cmd_valid = 1'b0;
    run_cycle("unm", 16'hC0A0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk1("unm_rsp", rsp_valid, 1'b1);
    chk8("unm_rdata", rsp_rdata, 8'h3C);

    // Reset asserted during P5 of a write.
    issue(16'hC093, 1'b1, 8'h77);
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    chk1("mid_pre_dev", nDEVSEL, 1'b0);
    chk1("mid_pre_oe", D_oe, 1'b1);
    #2 nRES = 1'b0;
    #1;
    chk1("mid_oe", D_oe, 1'b0);
    chk1("mid_dev", nDEVSEL, 1'b1);
    chk1("mid_nwe", nWE, 1'b1);
    chk16("mid_a", A, 16'h0000);
    chk1("mid_phi0", PHI0, 1'b0);
    chk1("mid_phi1", PHI1, 1'b1);
    chk8("mid_dout", D_out, 8'h00);
    repeat (3) @(negedge C7M);
    chk1("mid_rsp", rsp_valid, 1'b0);
    chk1("mid_rdy", cmd_ready, 1'b0);
    nRES = 1'b1;
    ph = 0;
    for (int p = 0; p <= 6; p++) begin
      if (p != 0) tick();
      chk1($sformatf("post_p%0d_rdy", p), cmd_ready, p == 6);
      chk1($sformatf("post_p%0d_rsp", p), rsp_valid, 1'b0);
      chk1($sformatf("post_p%0d_nwe", p), nWE, 1'b1);
      chk1($sformatf("post_p%0d_dev", p), nDEVSEL, 1'b1);
      chk1($sformatf("post_p%0d_phi0", p), PHI0, p >= 3);
    end
    tick();
    chk1("post_idle_rsp", rsp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
